// File: rtl/spram_rw_arbiter.sv
// spram_rw_arbiter
//   Shares one single-port SRAM between a write requester and a read
//   requester. At most one request is granted per cycle, and the SRAM command
//   is issued in the grant cycle. Read data returns RD_LATENCY cycles after
//   the read grant, qualified by rd_valid_o.
//
//   Optional feature macro: SPRAM_ARB_RR_EN
//     defined   - contention alternates between the requesters (round-robin,
//                 the first contention after reset goes to the write side)
//     undefined - the read requester always wins contention
//
// Parameters
//   WIDTH       data width
//   DEPTH       SRAM word count; AW = $clog2(DEPTH), minimum 1
//   RD_LATENCY  SRAM read latency in cycles (1..4)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wr_req_i/wr_addr_i/wr_data_i write request and payload
//   wr_gnt_o                     write granted this cycle
//   rd_req_i/rd_addr_i           read request and address
//   rd_gnt_o                     read granted this cycle
//   rd_data_o/rd_valid_o         returned read data and its valid strobe
//   sram_en_o/sram_we_o          SRAM enable and write-enable
//   sram_addr_o/sram_wdata_o     SRAM address and write data
//   sram_rdata_i                 SRAM read data
//   addr_err_o                   sticky: a granted request was out of range
module spram_rw_arbiter #(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 15,
    parameter int RD_LATENCY = 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_req_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_gnt_o,
    input  logic             rd_req_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic             rd_gnt_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             sram_en_o,
    output logic             sram_we_o,
    output logic [AW-1:0]    sram_addr_o,
    output logic [WIDTH-1:0] sram_wdata_o,
    input  logic [WIDTH-1:0] sram_rdata_i,
    output logic             addr_err_o
);

    // One extra bit so that DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic                  w_rd_wins;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic                  w_wr_inr;
    logic                  w_rd_inr;
    logic [RD_LATENCY-1:0] w_vld_nxt;
    logic [RD_LATENCY-1:0] w_inr_nxt;

    logic [RD_LATENCY-1:0] r_rd_vld;
    logic [RD_LATENCY-1:0] r_rd_inr;
    logic                  r_addr_err;

`ifdef SPRAM_ARB_RR_EN
    // 0 = write preferred on contention, 1 = read preferred.
    logic r_prio;

    assign w_rd_wins = r_prio;

    // Each contention hands preference to the side that just lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio <= 1'b0;
        end else if (wr_req_i && rd_req_i) begin
            r_prio <= w_wr_gnt;
        end
    end
`else
    assign w_rd_wins = 1'b1;
`endif

    assign w_wr_inr = {1'b0, wr_addr_i} < DEPTH_W;
    assign w_rd_inr = {1'b0, rd_addr_i} < DEPTH_W;

    // Grants are forced low while reset is asserted, whatever the requests.
    assign w_wr_gnt = !rst_i && wr_req_i && (!rd_req_i || !w_rd_wins);
    assign w_rd_gnt = !rst_i && rd_req_i && (!wr_req_i ||  w_rd_wins);

    assign wr_gnt_o = w_wr_gnt;
    assign rd_gnt_o = w_rd_gnt;

    // Out-of-range requests are still granted but never reach the macro.
    assign sram_en_o    = (w_wr_gnt && w_wr_inr) || (w_rd_gnt && w_rd_inr);
    assign sram_we_o    = w_wr_gnt;
    assign sram_addr_o  = w_wr_gnt ? wr_addr_i : (w_rd_gnt ? rd_addr_i : '0);
    assign sram_wdata_o = w_wr_gnt ? wr_data_i : '0;

    // Read tracking pipeline: grant bit plus its in-range flag.
    if (RD_LATENCY == 1) begin : g_lat1
        assign w_vld_nxt = w_rd_gnt;
        assign w_inr_nxt = w_rd_inr;
    end else begin : g_latn
        assign w_vld_nxt = {r_rd_vld[RD_LATENCY-2:0], w_rd_gnt};
        assign w_inr_nxt = {r_rd_inr[RD_LATENCY-2:0], w_rd_inr};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_vld <= '0;
            r_rd_inr <= '0;
        end else begin
            r_rd_vld <= w_vld_nxt;
            r_rd_inr <= w_inr_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr_err <= 1'b0;
        end else if ((w_wr_gnt && !w_wr_inr) || (w_rd_gnt && !w_rd_inr)) begin
            r_addr_err <= 1'b1;
        end
    end

    // Masked by rst_i so a read in flight when reset hits never strobes,
    // even in the reset cycle before the pipeline clears.
    assign rd_valid_o = !rst_i && r_rd_vld[RD_LATENCY-1];
    assign rd_data_o  = (rd_valid_o && r_rd_inr[RD_LATENCY-1]) ? sram_rdata_i : '0;
    assign addr_err_o = r_addr_err;

endmodule

// File: tb/tb_spram_rw_arbiter.sv
// Testbench for spram_rw_arbiter: directed scenarios plus randomized
// push/pop traffic, all compared cycle by cycle against a reference model
// (reference memory, expected-read queue, contention counter).
module tb_spram_rw_arbiter;

    localparam int WIDTH = 10;
    localparam int DEPTH = 15;
    localparam int RDL   = 3;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             wr_req_i = 1'b0;
    logic [AW-1:0]    wr_addr_i = '0;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic             wr_gnt_o;
    logic             rd_req_i = 1'b0;
    logic [AW-1:0]    rd_addr_i = '0;
    logic             rd_gnt_o;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             sram_en_o;
    logic             sram_we_o;
    logic [AW-1:0]    sram_addr_o;
    logic [WIDTH-1:0] sram_wdata_o;
    logic [WIDTH-1:0] sram_rdata_i;
    logic             addr_err_o;

    spram_rw_arbiter #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_req_i     (wr_req_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_gnt_o     (wr_gnt_o),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .sram_en_o    (sram_en_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .addr_err_o   (addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM macro with RDL-cycle read latency; idle slots return
    // all-ones so a missing zero-fill on out-of-range reads is visible.
    logic [WIDTH-1:0] sram_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rpipe    [0:RDL-1];
    always @(posedge clk_i) begin
        if (sram_en_o && sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
        rpipe[0] <= (sram_en_o && !sram_we_o) ? sram_mem[sram_addr_o] : '1;
        for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign sram_rdata_i = rpipe[RDL-1];

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model state.
    typedef struct {
        int unsigned      due;
        logic [WIDTH-1:0] data;
    } rd_t;
    rd_t              exp_q[$];
    logic [WIDTH-1:0] ref_mem [0:(1<<AW)-1];
    int unsigned      n_cont  = 0;   // contentions since reset
    bit               ref_err = 1'b0;
    bit               chk_en  = 1'b0;

    // Observation log.
    int unsigned      n_wg = 0, n_rg = 0, n_v = 0;
    logic [WIDTH-1:0] vq[$];
    int unsigned      vcyc[$];
    int unsigned      gcyc[$];

    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                bit               rwin, ew, er, iw, ir, ev;
                logic [WIDTH-1:0] ed;
`ifdef SPRAM_ARB_RR_EN
                rwin = n_cont[0];   // contentions alternate, write first
`else
                rwin = 1'b1;
`endif
                ew = !rst_i && wr_req_i && (!rd_req_i || !rwin);
                er = !rst_i && rd_req_i && (!wr_req_i || rwin);
                iw = int'(wr_addr_i) < DEPTH;
                ir = int'(rd_addr_i) < DEPTH;
                ev = !rst_i && exp_q.size() > 0 && exp_q[0].due == cyc;
                ed = ev ? exp_q[0].data : '0;

                check_val("wr_gnt",    32'(wr_gnt_o),   32'(ew));
                check_val("rd_gnt",    32'(rd_gnt_o),   32'(er));
                check_val("both_gnt",  32'(wr_gnt_o && rd_gnt_o), 32'd0);
                check_val("sram_en",   32'(sram_en_o),  32'((ew && iw) || (er && ir)));
                check_val("sram_we",   32'(sram_we_o),  32'(ew));
                check_val("sram_wdata", 32'(sram_wdata_o), ew ? 32'(wr_data_i) : 32'd0);
                if (ew)      check_val("sram_addr_w", 32'(sram_addr_o), 32'(wr_addr_i));
                else if (er) check_val("sram_addr_r", 32'(sram_addr_o), 32'(rd_addr_i));
                check_val("rd_valid",  32'(rd_valid_o), 32'(ev));
                if (ev) check_val("rd_data", 32'(rd_data_o), 32'(ed));
                check_val("addr_err",  32'(addr_err_o), 32'(ref_err));

                if (wr_gnt_o) n_wg++;
                if (rd_gnt_o) begin n_rg++; gcyc.push_back(cyc); end
                if (rd_valid_o) begin n_v++; vq.push_back(rd_data_o); vcyc.push_back(cyc); end

                // Advance the model across the coming clock edge.
                while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
                if (rst_i) begin
                    exp_q.delete();
                    n_cont  = 0;
                    ref_err = 1'b0;
                end else begin
                    if (wr_req_i && rd_req_i) n_cont++;
                    if ((ew && !iw) || (er && !ir)) ref_err = 1'b1;
                    if (er) exp_q.push_back('{due: cyc + RDL, data: ir ? ref_mem[rd_addr_i] : '0});
                    if (ew && iw) ref_mem[wr_addr_i] = wr_data_i;
                end
            end
        end
    end

    // All stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic reset_pulse();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bit ok = 1'b0;
        wr_addr_i = a;
        wr_data_i = d;
        wr_req_i  = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk_i);
            ok = wr_gnt_o;
            @(posedge clk_i);
            #1;
        end
        wr_req_i = 1'b0;
        if (!ok) check_val("wr_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit ok = 1'b0;
        rd_addr_i = a;
        rd_req_i  = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk_i);
            ok = rd_gnt_o;
            @(posedge clk_i);
            #1;
        end
        rd_req_i = 1'b0;
        if (!ok) check_val("rd_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        vq.delete();
        vcyc.delete();
        gcyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w0, r0, v0;
        @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        idle(2);
        check_val("reset_addr_err", 32'(addr_err_o), 32'd0);
        check_val("reset_rd_valid", 32'(rd_valid_o), 32'd0);
        rst_i = 1'b0;

        // Single write, then read of the same word two cycles later.
        clear_log();
        w0 = n_wg; r0 = n_rg;
        do_write(AW'(3), WIDTH'(10'h155));
        idle(1);
        do_read(AW'(3));
        idle(RDL + 2);
        check_val("t1_wr_gnts", n_wg - w0, 32'd1);
        check_val("t1_rd_gnts", n_rg - r0, 32'd1);
        check_val("t1_nvalid",  vq.size(), 32'd1);
        if (vq.size() == 1 && gcyc.size() == 1) begin
            check_val("t1_data",    32'(vq[0]), 32'h155);
            check_val("t1_latency", vcyc[0] - gcyc[0], RDL);
        end
        check_val("t1_addr_err", 32'(addr_err_o), 32'd0);

        // Both requesters held high for 8 cycles.
        reset_pulse();
        w0 = n_wg; r0 = n_rg;
        wr_addr_i = AW'(5); wr_data_i = WIDTH'(10'h2a5); rd_addr_i = AW'(6);
        wr_req_i = 1'b1; rd_req_i = 1'b1;
        idle(8);
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        idle(RDL + 1);
`ifdef SPRAM_ARB_RR_EN
        check_val("t2_wr_gnts", n_wg - w0, 32'd4);
        check_val("t2_rd_gnts", n_rg - r0, 32'd4);
`else
        check_val("t2_wr_gnts", n_wg - w0, 32'd0);
        check_val("t2_rd_gnts", n_rg - r0, 32'd8);
`endif

        // Burst of 5 back-to-back reads of previously written words.
        for (int i = 0; i < 5; i++) do_write(AW'(i), WIDTH'(10 + i));
        clear_log();
        for (int i = 0; i < 5; i++) do_read(AW'(i));
        idle(RDL + 2);
        check_val("t3_nvalid", vq.size(), 32'd5);
        if (vq.size() == 5 && gcyc.size() == 5) begin
            check_val("t3_first_lat", vcyc[0] - gcyc[0], RDL);
            for (int i = 0; i < 5; i++) begin
                check_val("t3_data", 32'(vq[i]), 32'(10 + i));
                check_val("t3_consec", vcyc[i] - vcyc[0], 32'(i));
            end
        end

        // Out-of-range write, then out-of-range read, then reset clears error.
        do_write(AW'(15), WIDTH'(10'h3c3));
        check_val("t4_err_set", 32'(addr_err_o), 32'd1);
        clear_log();
        do_read(AW'(15));
        idle(RDL + 2);
        check_val("t4_oor_nvalid", vq.size(), 32'd1);
        if (vq.size() == 1) check_val("t4_oor_data", 32'(vq[0]), 32'd0);
        check_val("t4_err_sticky", 32'(addr_err_o), 32'd1);
        rst_i = 1'b1;
        idle(1);
        check_val("t4_err_cleared", 32'(addr_err_o), 32'd0);
        rst_i = 1'b0;

        // Reset while a read is in flight.
        idle(1);
        v0 = n_v;
        do_read(AW'(2));
        rst_i = 1'b1;
        idle(1);
        check_val("t5_valid_in_rst", 32'(rd_valid_o), 32'd0);
        check_val("t5_en_in_rst",    32'(sram_en_o),  32'd0);
        idle(1);
        rst_i = 1'b0;
        idle(RDL + 3);
        check_val("t5_no_valid", n_v - v0, 32'd0);

        // Preload every word, then random concurrent traffic.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), WIDTH'($urandom));
        v0 = n_v; r0 = n_rg;
        fork
            begin
                for (int n = 0; n < 500; n++) begin
                    idle($urandom_range(0, 10));
                    do_write(AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
                end
            end
            begin
                for (int n = 0; n < 500; n++) begin
                    idle($urandom_range(0, 10));
                    do_read(AW'($urandom_range(0, DEPTH - 1)));
                end
            end
        join
        idle(RDL + 2);
        check_val("t6_valid_count", n_v - v0, n_rg - r0);
        check_val("t6_err_clear", 32'(addr_err_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spram_rw_arbiter.md
# spram_rw_arbiter

Shares one single-port SRAM macro between a write requester and a read requester, so the single-port FIFO and other single-port buffers can present independent push/pop paths. Each cycle it grants at most one request, drives the SRAM command port, and returns read data with a fixed-latency valid strobe. Contention is resolved round-robin, or by fixed read priority when the fairness feature is compiled out.

## Interface

- WIDTH, 10, data width in bits
- DEPTH, 15, SRAM word count; AW = $clog2(DEPTH) (minimum 1)
- RD_LATENCY, 1, SRAM read latency in cycles (1..4)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_req_i  in  1  write request
- wr_addr_i  in  AW  write address
- wr_data_i  in  WIDTH  write data
- wr_gnt_o  out  1  write granted this cycle (handshake)
- rd_req_i  in  1  read request
- rd_addr_i  in  AW  read address
- rd_gnt_o  out  1  read granted this cycle (handshake)
- rd_data_o  out  WIDTH  read data, qualified by rd_valid_o
- rd_valid_o  out  1  read data valid strobe
- sram_en_o  out  1  SRAM access enable
- sram_we_o  out  1  1 = write, 0 = read
- sram_addr_o  out  AW  SRAM address
- sram_wdata_o  out  WIDTH  SRAM write data
- sram_rdata_i  in  WIDTH  SRAM read data
- addr_err_o  out  1  sticky: a granted request had address >= DEPTH

## Operation

- Requesters hold req and payload stable until gnt; a transfer completes on the cycle req && gnt.
- Single request: granted the same cycle.
- Both requesting (contention): winner chosen by 1-bit priority register `prio` (0 = write preferred, 1 = read preferred). On every contention cycle, `prio` is set to prefer the loser. Non-contention cycles leave `prio` unchanged.
- Never both grants in one cycle; sram_en_o = wr_gnt_o | rd_gnt_o when address is in range.
- sram_we_o = wr_gnt_o; sram_addr_o/sram_wdata_o muxed from the granted requester; sram_wdata_o = wr_data_i whenever write is granted, otherwise don't-care (drive 0).
- Address >= DEPTH: request still granted (no deadlock), sram_en_o held 0, addr_err_o set and held until reset. Out-of-range reads still produce rd_valid_o with rd_data_o = 0.
- Read tracking: RD_LATENCY-deep shift register of the read-grant bit, plus a matching in-range flag.
- rd_data_o = sram_rdata_i when the tracked access was in range, else 0.

## Timing

- Grants are combinational from req and `prio`; the SRAM command is issued in the grant cycle.
- rd_valid_o asserts exactly RD_LATENCY cycles after the rd_gnt_o cycle, for one cycle per granted read. Back-to-back reads give back-to-back valids.
- Write to address A in cycle t, then read of A granted at t+1: returns the new data (SRAM write-first is not required, because the accesses are in different cycles).
- Reset values:
  - wr_gnt_o = rd_gnt_o = 0 during reset regardless of req.
  - sram_en_o = 0, sram_we_o = 0.
  - rd_valid_o = 0, addr_err_o = 0.
  - `prio` = 0, the read pipeline cleared.
- Reset mid-operation: in-flight reads are discarded, and no rd_valid_o fires for them after reset deasserts.
- First cycle after reset: accepts requests normally.

## Configuration

- SPRAM_ARB_RR_EN defined: round-robin contention as above, with bounded wait of 1 cycle for either requester.
- Not defined: `prio` is removed and read always wins contention. Writes can starve under continuous reads; the system level must guarantee read gaps.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then write 0x155 to addr 3, and read addr 3 two cycles later. Required: one wr_gnt, one rd_gnt, rd_valid_o at grant+RD_LATENCY with rd_data_o = 0x155, addr_err_o = 0.
- Both requesters held high for 8 cycles (RR build). Required: grants alternate W,R,W,R… starting with W, and 4 SRAM writes and 4 reads are issued. Without the macro: 8 read grants and 0 write grants.
- Burst of 5 reads to addrs 0..4 previously written 10..14, with RD_LATENCY = 3. Required: 5 consecutive rd_valid_o cycles starting 3 cycles after the first grant, with data 10..14 in order.
- Write to addr 15 with DEPTH = 15. Required: wr_gnt_o = 1, sram_en_o = 0, and addr_err_o = 1 from the next cycle, sticky until rst_i.
- Read granted, then rst_i asserted before its valid would fire. Required: no rd_valid_o during or after reset, and all outputs at their reset values the cycle after rst_i is sampled.
- Randomized push/pop traffic with a scoreboard (1000 transfers, random idle gaps 0..10). Required: read data matches a reference memory model and no cycle has both grants.
